// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and widths for the MEM stage controller.
package mem_stage_ctrl_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/ack bus between the MEM stage (master) and memory (slave).
interface mem_stage_ctrl_if;
    import mem_stage_ctrl_pkg::*;

    logic          bus_req;
    logic          bus_we;
    logic [DW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );

endinterface

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register; bubble forces a non-writing slot and holds data/dest.
module mem_wb_reg
    import mem_stage_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          bubble,
    input  logic [DW-1:0] data_d,
    input  logic          wen_d,
    input  logic [RW-1:0] waddr_d,
    output logic [DW-1:0] data_q,
    output logic          wen_q,
    output logic [RW-1:0] waddr_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
        end else if (bubble) begin
            wen_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: runs the EX/MEM data-memory access over a req/ack bus with timeout,
// stalls the pipeline meanwhile, and feeds the MEM/WB register.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned   TIMEOUT  = 16,
    parameter logic [DW-1:0] ERR_DATA = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   alu_result,
    input  logic [DW-1:0]   rdata2,
    input  logic            mem_wen,
    input  logic            mem_ren,
    input  logic            mem_to_reg,
    input  logic            reg_wen,
    input  logic [RW-1:0]   reg_waddr,
    mem_stage_ctrl_if.master bus,
    output logic            stall,
    output logic [DW-1:0]   wb_data_out,
    output logic            wb_reg_wen_out,
    output logic [RW-1:0]   wb_reg_waddr_out,
    output logic            mem_err_out
);

    localparam int unsigned  CW      = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          req_q, we_q, err_q, mem_err_q;
    logic [DW-1:0] addr_q, wdata_q, rdata_q;
    logic          mem_op, timeout;
    logic          wb_bubble;
    logic [DW-1:0] wb_data_d;

    assign mem_op  = mem_wen | mem_ren;
    assign timeout = (state_q == ST_WAIT) && !bus.bus_ack && (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        wb_bubble = 1'b1;
        wb_data_d = alu_result;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    stall   = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    wb_bubble = 1'b0;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (bus.bus_ack || timeout) state_d = ST_DONE;
            end
            ST_DONE: begin
                // EX/MEM is still held this cycle, so its controls describe the finished op
                wb_bubble = 1'b0;
                wb_data_d = (mem_to_reg && !we_q) ? rdata_q : alu_result;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_op) begin
                        req_q   <= 1'b1;
                        we_q    <= mem_wen;
                        addr_q  <= alu_result;
                        wdata_q <= rdata2;
                        cnt_q   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (bus.bus_ack) begin
                        if (!we_q) rdata_q <= bus.bus_rdata;
                        req_q <= 1'b0;
                    end else if (timeout) begin
                        rdata_q <= ERR_DATA;
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    mem_err_q <= err_q;
                    err_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign mem_err_out   = mem_err_q;

    mem_wb_reg u_mem_wb_reg (
        .clk     (clk),
        .rst     (rst),
        .bubble  (wb_bubble),
        .data_d  (wb_data_d),
        .wen_d   (reg_wen),
        .waddr_d (reg_waddr),
        .data_q  (wb_data_out),
        .wen_q   (wb_reg_wen_out),
        .waddr_q (wb_reg_waddr_out)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with TIMEOUT=4.
module tb_mem_stage_ctrl;
    import mem_stage_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] alu_result, rdata2;
    logic          mem_wen, mem_ren, mem_to_reg, reg_wen;
    logic [RW-1:0] reg_waddr;
    logic          stall;
    logic [DW-1:0] wb_data_out;
    logic          wb_reg_wen_out;
    logic [RW-1:0] wb_reg_waddr_out;
    logic          mem_err_out;

    int checks   = 0;
    int failures = 0;

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl #(.TIMEOUT(4), .ERR_DATA(16'h0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .alu_result       (alu_result),
        .rdata2           (rdata2),
        .mem_wen          (mem_wen),
        .mem_ren          (mem_ren),
        .mem_to_reg       (mem_to_reg),
        .reg_wen          (reg_wen),
        .reg_waddr        (reg_waddr),
        .bus              (bus.master),
        .stall            (stall),
        .wb_data_out      (wb_data_out),
        .wb_reg_wen_out   (wb_reg_wen_out),
        .wb_reg_waddr_out (wb_reg_waddr_out),
        .mem_err_out      (mem_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to 2 time units after the next rising edge; inputs change here
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_in();
        mem_wen = 0; mem_ren = 0; mem_to_reg = 0; reg_wen = 0;
        reg_waddr = '0; alu_result = '0; rdata2 = '0;
        bus.bus_ack = 0; bus.bus_rdata = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; idle_in();
        step(); step();
        settle();
        chk("rst_req", bus.bus_req, 0);
        chk("rst_wb_data", wb_data_out, 0);
        chk("rst_wb_wen", wb_reg_wen_out, 0);
        chk("rst_err", mem_err_out, 0);

        // ALU op passes through with one-cycle latency
        rst = 0; alu_result = 16'h1234; reg_wen = 1; reg_waddr = 4'd3; settle();
        chk("alu_stall", stall, 0);
        step(); idle_in(); settle();
        chk("alu_wb_data", wb_data_out, 16'h1234);
        chk("alu_wb_wen", wb_reg_wen_out, 1);
        chk("alu_wb_waddr", wb_reg_waddr_out, 3);
        chk("alu_stall2", stall, 0);

        // load, ack on third WAIT cycle
        mem_ren = 1; alu_result = 16'h0040; mem_to_reg = 1; reg_wen = 1; reg_waddr = 4'd5; settle();
        chk("ld_idle_stall", stall, 1);
        chk("ld_idle_req", bus.bus_req, 0);
        step(); settle();
        chk("ld_w1_req", bus.bus_req, 1);
        chk("ld_w1_addr", bus.bus_addr, 16'h0040);
        chk("ld_w1_we", bus.bus_we, 0);
        chk("ld_w1_stall", stall, 1);
        chk("ld_w1_bubble", wb_reg_wen_out, 0);
        step(); settle();
        chk("ld_w2_req", bus.bus_req, 1);
        chk("ld_w2_addr", bus.bus_addr, 16'h0040);
        step(); bus.bus_ack = 1; bus.bus_rdata = 16'hBEEF; settle();
        chk("ld_w3_req", bus.bus_req, 1);
        chk("ld_w3_stall", stall, 1);
        step(); bus.bus_ack = 0; bus.bus_rdata = '0; settle();
        chk("ld_done_req", bus.bus_req, 0);
        chk("ld_done_stall", stall, 0);
        chk("ld_done_wen", wb_reg_wen_out, 0);
        step(); idle_in(); settle();
        chk("ld_wb_data", wb_data_out, 16'hBEEF);
        chk("ld_wb_wen", wb_reg_wen_out, 1);
        chk("ld_wb_waddr", wb_reg_waddr_out, 5);
        chk("ld_after_stall", stall, 0);

        // store with ren also set (write wins), zero-wait ack
        mem_wen = 1; mem_ren = 1; alu_result = 16'h0010; rdata2 = 16'hA5A5; reg_waddr = 4'd7; settle();
        chk("st_idle_stall", stall, 1);
        step(); bus.bus_ack = 1; bus.bus_rdata = 16'hFFFF; settle();
        chk("st_req", bus.bus_req, 1);
        chk("st_we", bus.bus_we, 1);
        chk("st_wdata", bus.bus_wdata, 16'hA5A5);
        chk("st_addr", bus.bus_addr, 16'h0010);
        step(); bus.bus_ack = 0; settle();
        chk("st_done_req", bus.bus_req, 0);
        chk("st_done_stall", stall, 0);
        step(); idle_in(); settle();
        chk("st_wb_wen", wb_reg_wen_out, 0);
        chk("st_wb_data", wb_data_out, 16'h0010);
        chk("st_wb_waddr", wb_reg_waddr_out, 7);
        chk("st_err", mem_err_out, 0);

        // load with no ack: abort after 4 WAIT cycles
        mem_ren = 1; alu_result = 16'h0080; mem_to_reg = 1; reg_wen = 1; reg_waddr = 4'd9; settle();
        for (int i = 0; i < 4; i++) begin
            step(); settle();
            chk($sformatf("to_w%0d_req", i + 1), bus.bus_req, 1);
            chk($sformatf("to_w%0d_err", i + 1), mem_err_out, 0);
        end
        step(); settle();
        chk("to_done_req", bus.bus_req, 0);
        chk("to_done_stall", stall, 0);
        chk("to_done_err", mem_err_out, 0);
        step(); idle_in(); settle();
        chk("to_wb_data", wb_data_out, 16'h0000);
        chk("to_wb_wen", wb_reg_wen_out, 1);
        chk("to_wb_waddr", wb_reg_waddr_out, 9);
        chk("to_err_pulse", mem_err_out, 1);
        step(); settle();
        chk("to_err_clear", mem_err_out, 0);

        // reset during WAIT, late ack ignored
        mem_ren = 1; alu_result = 16'h00C0; mem_to_reg = 1; reg_wen = 1; reg_waddr = 4'd4; settle();
        step(); rst = 1; settle();
        chk("rw_w1_req", bus.bus_req, 1);
        step(); rst = 0; idle_in(); bus.bus_ack = 1; bus.bus_rdata = 16'h1111; settle();
        chk("rw_req", bus.bus_req, 0);
        chk("rw_addr", bus.bus_addr, 0);
        chk("rw_stall", stall, 0);
        chk("rw_wb_data", wb_data_out, 0);
        chk("rw_wb_wen", wb_reg_wen_out, 0);
        chk("rw_wb_waddr", wb_reg_waddr_out, 0);
        step(); bus.bus_ack = 0; settle();
        chk("rw_req2", bus.bus_req, 0);
        chk("rw_wb_wen2", wb_reg_wen_out, 0);
        chk("rw_err2", mem_err_out, 0);

        // two back-to-back loads
        mem_ren = 1; mem_to_reg = 1; reg_wen = 1; alu_result = 16'h0100; reg_waddr = 4'd1; settle();
        step(); bus.bus_ack = 1; bus.bus_rdata = 16'h1111; settle();
        chk("bb1_req", bus.bus_req, 1);
        chk("bb1_addr", bus.bus_addr, 16'h0100);
        step(); bus.bus_ack = 0; settle();
        chk("bb1_done_req", bus.bus_req, 0);
        step(); alu_result = 16'h0200; reg_waddr = 4'd2; settle();
        chk("bb_gap_req", bus.bus_req, 0);
        chk("bb_gap_stall", stall, 1);
        chk("bb1_wb_data", wb_data_out, 16'h1111);
        chk("bb1_wb_waddr", wb_reg_waddr_out, 1);
        chk("bb1_wb_wen", wb_reg_wen_out, 1);
        step(); bus.bus_ack = 1; bus.bus_rdata = 16'h2222; settle();
        chk("bb2_req", bus.bus_req, 1);
        chk("bb2_addr", bus.bus_addr, 16'h0200);
        chk("bb2_bubble", wb_reg_wen_out, 0);
        step(); bus.bus_ack = 0; settle();
        chk("bb2_done_req", bus.bus_req, 0);
        step(); idle_in(); bus.bus_ack = 1; settle();
        chk("bb2_wb_data", wb_data_out, 16'h2222);
        chk("bb2_wb_waddr", wb_reg_waddr_out, 2);
        chk("bb2_wb_wen", wb_reg_wen_out, 1);
        // stray ack while IDLE must not start anything
        step(); bus.bus_ack = 0; settle();
        chk("stray_ack_req", bus.bus_req, 0);
        chk("stray_ack_stall", stall, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
